// File: rtl/input_vc_buffer.sv
// Input virtual-channel buffer for a NoC router port.
// Holds flits of one packet at a time in a circular FIFO and walks the
// packet through VC allocation (VA) and switch allocation (SA).
// noc_params supplies the flit format shared across the router.

package noc_params;

    localparam int VC_SIZE        = 2;
    localparam int PORT_SIZE      = 3;
    localparam int FLIT_DATA_SIZE = 16;

    typedef enum logic [1:0] {
        HEAD     = 2'd0,
        BODY     = 2'd1,
        TAIL     = 2'd2,
        HEADTAIL = 2'd3
    } flit_label_t;

    typedef logic [PORT_SIZE-1:0] port_t;

    typedef struct packed {
        flit_label_t               flit_label;
        logic [FLIT_DATA_SIZE-1:0] data;
    } flit_t;

endpackage

module input_vc_buffer
    import noc_params::*;
#(
    // FIFO depth in flits; must be a power of two, at least 2
    parameter int BUFFER_SIZE = 8
)
(
    input  logic               clk,
    input  logic               rst,
    input  flit_t              data_i,
    input  logic               valid_i,
    input  port_t              out_port_i,
    input  logic               read_i,
    output logic               vc_request_o,
    output port_t              out_port_o,
    input  logic               vc_valid_i,
    input  logic [VC_SIZE-1:0] vc_new_i,
    output logic [VC_SIZE-1:0] downstream_vc_o,
    output logic               switch_request_o,
    output flit_t              data_o,
    output logic               is_full_o,
    output logic               is_empty_o,
    output logic               idle_o,
    output logic               error_o
);

    localparam int PTR_W = $clog2(BUFFER_SIZE);
    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W+1)'(BUFFER_SIZE);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        VA   = 2'd1,
        SA   = 2'd2
    } state_t;

    // Packet context and control state
    state_t               state_q;
    port_t                out_port_q;
    logic [VC_SIZE-1:0]   downstream_vc_q;

    // FIFO bookkeeping
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]       count_q,  count_d;
    logic                 error_q,  error_d;

    // Flit storage; contents are don't-care while the count says empty
    flit_t                mem_q [BUFFER_SIZE];

    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 in_is_head;
    logic                 out_is_tail;
    logic                 label_ok;
    logic                 space_ok;
    logic                 wr_en;
    logic                 pop;

    assign fifo_full   = (count_q == FULL_COUNT);
    assign fifo_empty  = (count_q == '0);

    assign in_is_head  = (data_i.flit_label == HEAD) || (data_i.flit_label == HEADTAIL);
    assign out_is_tail = (data_o.flit_label == TAIL) || (data_o.flit_label == HEADTAIL);

    // Only SA may drain the FIFO; read_i is ignored everywhere else
    assign pop         = read_i && !fifo_empty && (state_q == SA);

    // A head starts a packet only from IDLE; body/tail only extend a live packet
    assign label_ok    = (state_q == IDLE) ? in_is_head : !in_is_head;

    // A full FIFO still takes a write when the same cycle frees a slot
    assign space_ok    = !fifo_full || pop;

    assign wr_en       = valid_i && label_ok && space_ok;

    // Compute next pointers, occupancy and the drop indication
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        error_d  = valid_i && !wr_en;

        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        case ({wr_en, pop})
            2'b10:   count_d = count_q + (PTR_W+1)'(1);
            2'b01:   count_d = count_q - (PTR_W+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // FIFO control registers, cleared immediately on reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            error_q  <= 1'b0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            error_q  <= error_d;
        end
    end

    // Flit storage write port; no reset needed since the count gates visibility
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    // Packet state machine: latches route on head, VC on grant, returns on tail pop
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= IDLE;
            out_port_q      <= '0;
            downstream_vc_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (wr_en) begin
                        out_port_q <= out_port_i;
                        state_q    <= VA;
                    end
                end
                VA: begin
                    if (vc_valid_i) begin
                        downstream_vc_q <= vc_new_i;
                        state_q         <= SA;
                    end
                end
                SA: begin
                    if (pop && out_is_tail) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign data_o           = mem_q[rd_ptr_q];
    assign is_full_o        = fifo_full;
    assign is_empty_o       = fifo_empty;
    assign vc_request_o     = (state_q == VA);
    assign switch_request_o = (state_q == SA) && !fifo_empty;
    assign idle_o           = (state_q == IDLE) && fifo_empty;
    assign out_port_o       = out_port_q;
    assign downstream_vc_o  = downstream_vc_q;
    assign error_o          = error_q;

endmodule

// File: tb/tb_input_vc_buffer.sv
// Directed bench for input_vc_buffer with a flit scoreboard.
// Expected flits are queued when driven and compared when the DUT pops them.

module tb_input_vc_buffer;

    import noc_params::*;

    localparam int BUFFER_SIZE = 8;

    logic               clk = 1'b0;
    logic               rst;
    flit_t              data_i;
    logic               valid_i;
    port_t              out_port_i;
    logic               read_i;
    logic               vc_request_o;
    port_t              out_port_o;
    logic               vc_valid_i;
    logic [VC_SIZE-1:0] vc_new_i;
    logic [VC_SIZE-1:0] downstream_vc_o;
    logic               switch_request_o;
    flit_t              data_o;
    logic               is_full_o;
    logic               is_empty_o;
    logic               idle_o;
    logic               error_o;

    flit_t sb[$];
    int    checks = 0;
    int    errors = 0;
    int    pops   = 0;
    int    vcreq  = 0;

    always #5 clk = ~clk;

    input_vc_buffer #(.BUFFER_SIZE(BUFFER_SIZE)) dut (
        .clk             (clk),
        .rst             (rst),
        .data_i          (data_i),
        .valid_i         (valid_i),
        .out_port_i      (out_port_i),
        .read_i          (read_i),
        .vc_request_o    (vc_request_o),
        .out_port_o      (out_port_o),
        .vc_valid_i      (vc_valid_i),
        .vc_new_i        (vc_new_i),
        .downstream_vc_o (downstream_vc_o),
        .switch_request_o(switch_request_o),
        .data_o          (data_o),
        .is_full_o       (is_full_o),
        .is_empty_o      (is_empty_o),
        .idle_o          (idle_o),
        .error_o         (error_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic flit_t mk(input flit_label_t l, input logic [15:0] d);
        flit_t f;
        f.flit_label = l;
        f.data       = d;
        return f;
    endfunction

    // Drive a write; keep=1 means the flit is expected to be stored
    task automatic wr(input flit_label_t l, input logic [15:0] d, input port_t p, input bit keep);
        valid_i    = 1'b1;
        data_i     = mk(l, d);
        out_port_i = p;
        if (keep) sb.push_back(mk(l, d));
    endtask

    // Advance one cycle; a pop seen before the edge is checked against the scoreboard
    task automatic tick();
        #2;
        if (read_i && switch_request_o) begin
            checks++;
            assert (sb.size() != 0) else begin
                errors++;
                $error("FAIL pop_unexpected observed=%0h expected=no_pop", 32'(data_o));
            end
            if (sb.size() != 0) chk("pop_data", 32'(data_o), 32'(sb.pop_front()));
            pops++;
        end
        @(posedge clk);
        #1;
        valid_i    = 1'b0;
        vc_valid_i = 1'b0;
        read_i     = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst        = 1'b1;
        data_i     = mk(BODY, 16'h0);
        valid_i    = 1'b0;
        out_port_i = '0;
        read_i     = 1'b0;
        vc_valid_i = 1'b0;
        vc_new_i   = '0;

        // Reset state
        #3;
        chk("rst_empty",    32'(is_empty_o),       1);
        chk("rst_full",     32'(is_full_o),        0);
        chk("rst_idle",     32'(idle_o),           1);
        chk("rst_vcreq",    32'(vc_request_o),     0);
        chk("rst_swreq",    32'(switch_request_o), 0);
        chk("rst_error",    32'(error_o),          0);
        chk("rst_outport",  32'(out_port_o),       0);
        chk("rst_dvc",      32'(downstream_vc_o),  0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Scenario 1: HEAD/BODY/TAIL, grant in first VA cycle, read held high
        wr(HEAD, 16'h0011, 3'd2, 1'b1); read_i = 1'b1; tick();
        chk("s1_vcreq_va",  32'(vc_request_o),     1);
        chk("s1_outport",   32'(out_port_o),       2);
        chk("s1_swreq_va",  32'(switch_request_o), 0);
        wr(BODY, 16'h0012, 3'd0, 1'b1); vc_valid_i = 1'b1; vc_new_i = 2'd1; read_i = 1'b1; tick();
        chk("s1_vcreq_sa",  32'(vc_request_o),     0);
        chk("s1_dvc",       32'(downstream_vc_o),  1);
        chk("s1_swreq_sa",  32'(switch_request_o), 1);
        wr(TAIL, 16'h0013, 3'd0, 1'b1); read_i = 1'b1; tick();
        read_i = 1'b1; tick();
        read_i = 1'b1; tick();
        chk("s1_pops",      32'(pops),             3);
        chk("s1_idle",      32'(idle_o),           1);
        chk("s1_empty",     32'(is_empty_o),       1);
        chk("s1_sb_empty",  32'(sb.size()),        0);
        chk("s1_hold_port", 32'(out_port_o),       2);
        chk("s1_hold_vc",   32'(downstream_vc_o),  1);

        // Scenario 2: HEADTAIL with grant withheld for 5 cycles
        wr(HEADTAIL, 16'h0021, 3'd3, 1'b1); tick();
        vcreq = 0;
        for (int i = 0; i < 5; i++) begin
            read_i = 1'b1;
            if (vc_request_o) vcreq++;
            chk("s2_swreq_wait", 32'(switch_request_o), 0);
            tick();
        end
        if (vc_request_o) vcreq++;
        vc_valid_i = 1'b1; vc_new_i = 2'd2; read_i = 1'b1; tick();
        chk("s2_vcreq_cycles", 32'(vcreq),            6);
        chk("s2_vcreq_sa",     32'(vc_request_o),     0);
        chk("s2_dvc",          32'(downstream_vc_o),  2);
        chk("s2_swreq_sa",     32'(switch_request_o), 1);
        read_i = 1'b1; tick();
        chk("s2_pops",         32'(pops),             4);
        chk("s2_idle",         32'(idle_o),           1);
        chk("s2_outport",      32'(out_port_o),       3);

        // Scenario 3: fill to 8, overflow drop, then write+pop while full
        wr(HEAD, 16'h0030, 3'd1, 1'b1); tick();
        for (int i = 1; i < 8; i++) begin
            wr(BODY, 16'(16'h0030 + i), 3'd0, 1'b1); tick();
        end
        chk("s3_full",         32'(is_full_o),        1);
        chk("s3_no_err_fill",  32'(error_o),          0);
        wr(BODY, 16'h0038, 3'd0, 1'b0); tick();
        chk("s3_err_overflow", 32'(error_o),          1);
        chk("s3_full_after",   32'(is_full_o),        1);
        tick();
        chk("s3_err_single",   32'(error_o),          0);
        vc_valid_i = 1'b1; vc_new_i = 2'd3; tick();
        chk("s3_swreq",        32'(switch_request_o), 1);
        chk("s3_dvc",          32'(downstream_vc_o),  3);
        wr(BODY, 16'h0039, 3'd0, 1'b1); read_i = 1'b1; tick();
        chk("s3_err_wr_pop",   32'(error_o),          0);
        chk("s3_full_wr_pop",  32'(is_full_o),        1);
        wr(TAIL, 16'h003A, 3'd0, 1'b1); read_i = 1'b1; tick();
        chk("s3_err_tail_pop", 32'(error_o),          0);
        for (int i = 0; i < 8; i++) begin
            read_i = 1'b1; tick();
        end
        chk("s3_idle",         32'(idle_o),           1);
        chk("s3_sb_empty",     32'(sb.size()),        0);

        // Scenario 4: BODY in IDLE (with stray grant), HEAD during SA
        wr(BODY, 16'h0040, 3'd0, 1'b0); vc_valid_i = 1'b1; vc_new_i = 2'd0; tick();
        chk("s4_err_body_idle", 32'(error_o),         1);
        chk("s4_empty",         32'(is_empty_o),      1);
        chk("s4_idle",          32'(idle_o),          1);
        chk("s4_grant_ignored", 32'(downstream_vc_o), 3);
        tick();
        chk("s4_err_clear",     32'(error_o),         0);
        wr(HEAD, 16'h0041, 3'd4, 1'b1); tick();
        vc_valid_i = 1'b1; vc_new_i = 2'd1; tick();
        wr(HEAD, 16'h0042, 3'd5, 1'b0); tick();
        chk("s4_err_head_sa",   32'(error_o),         1);
        chk("s4_port_kept",     32'(out_port_o),      4);
        wr(TAIL, 16'h0043, 3'd0, 1'b1); tick();
        chk("s4_err_tail_ok",   32'(error_o),         0);
        read_i = 1'b1; tick();
        read_i = 1'b1; tick();
        chk("s4_idle_end",      32'(idle_o),          1);
        chk("s4_sb_empty",      32'(sb.size()),       0);

        // Scenario 5: 10 back-to-back packets, pointers wrap several times
        pops = 0;
        for (int p = 0; p < 10; p++) begin
            begin
                int n;
                n = 0;
                while (!idle_o && n < 10) begin
                    read_i = 1'b1; tick(); n++;
                end
                chk("s5_idle_wait", 32'(idle_o), 1);
            end
            wr(HEAD, 16'(16'h5000 + p * 4), 3'(p % 8), 1'b1); read_i = 1'b1; tick();
            chk("s5_outport", 32'(out_port_o), 32'(p % 8));
            wr(BODY, 16'(16'h5001 + p * 4), 3'd0, 1'b1); vc_valid_i = 1'b1; vc_new_i = 2'(p % 4);
            read_i = 1'b1; tick();
            chk("s5_dvc", 32'(downstream_vc_o), 32'(p % 4));
            wr(TAIL, 16'(16'h5002 + p * 4), 3'd0, 1'b1); read_i = 1'b1; tick();
        end
        begin
            int n;
            n = 0;
            while (!idle_o && n < 10) begin
                read_i = 1'b1; tick(); n++;
            end
            chk("s5_drain_idle", 32'(idle_o), 1);
        end
        chk("s5_pops",     32'(pops),      30);
        chk("s5_sb_empty", 32'(sb.size()), 0);

        // Scenario 6: asynchronous reset in SA with 3 flits stored
        wr(HEAD, 16'h0061, 3'd6, 1'b1); tick();
        wr(BODY, 16'h0062, 3'd0, 1'b1); vc_valid_i = 1'b1; vc_new_i = 2'd3; tick();
        wr(BODY, 16'h0063, 3'd0, 1'b1); tick();
        chk("s6_swreq_pre", 32'(switch_request_o), 1);
        chk("s6_dvc_pre",   32'(downstream_vc_o),  3);
        #3;
        rst = 1'b1;
        #1;
        chk("s6_empty",   32'(is_empty_o),       1);
        chk("s6_idle",    32'(idle_o),           1);
        chk("s6_dvc",     32'(downstream_vc_o),  0);
        chk("s6_outport", 32'(out_port_o),       0);
        chk("s6_vcreq",   32'(vc_request_o),     0);
        chk("s6_swreq",   32'(switch_request_o), 0);
        chk("s6_full",    32'(is_full_o),        0);
        sb.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        wr(HEADTAIL, 16'h0064, 3'd1, 1'b1); tick();
        chk("s6_post_vcreq", 32'(vc_request_o), 1);
        vc_valid_i = 1'b1; vc_new_i = 2'd1; tick();
        read_i = 1'b1; tick();
        chk("s6_post_idle",  32'(idle_o),          1);
        chk("s6_post_dvc",   32'(downstream_vc_o), 1);
        chk("s6_sb_empty",   32'(sb.size()),       0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/input_vc_buffer.md
INPUT_VC_BUFFER -- requirements
Module: input_vc_buffer

Interface
REQ-001 The block SHALL have parameter BUFFER_SIZE, default 8, giving FIFO depth in flits; it SHALL be a power of two and at least 2.
REQ-002 The block SHALL use flit_t, port_t, VC_SIZE and the flit labels HEAD, BODY, TAIL and HEADTAIL from noc_params.
REQ-003 Port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 Port rst  input  1  reset, asynchronous and active-high.
REQ-005 Port data_i  input  flit_t  incoming flit from the upstream link.
REQ-006 Port valid_i  input  1  write strobe for data_i.
REQ-007 Port out_port_i  input  port_t  route-computation result for data_i; meaningful only with a head flit.
REQ-008 Port read_i  input  1  switch-traversal pop of the head-of-FIFO flit.
REQ-009 Port vc_request_o  output  1  downstream VC allocation request.
REQ-010 Port out_port_o  output  port_t  latched output port of the current packet.
REQ-011 Port vc_valid_i  input  1  allocation grant.
REQ-012 Port vc_new_i  input  VC_SIZE  granted downstream VC, valid with vc_valid_i.
REQ-013 Port downstream_vc_o  output  VC_SIZE  latched downstream VC of the current packet.
REQ-014 Port switch_request_o  output  1  FIFO non-empty and the block is in state SA.
REQ-015 Port data_o  output  flit_t  head-of-FIFO flit, combinational from storage.
REQ-016 Port is_full_o / is_empty_o  output  1 each  FIFO occupancy flags.
REQ-017 Port idle_o  output  1  high in state IDLE with an empty FIFO; this is the idle indication the upstream allocator uses to free this VC.
REQ-018 Port error_o  output  1  single-cycle pulse on any dropped write.

Function
REQ-019 The FIFO SHALL be circular, with read and write pointers of log2(BUFFER_SIZE) bits that wrap modulo BUFFER_SIZE and an occupancy count of log2(BUFFER_SIZE)+1 bits.
REQ-020 A write SHALL be accepted when valid_i is high and the FIFO is not full, or the FIFO is full and read_i pops in the same cycle.
REQ-021 A pop SHALL occur only when read_i is high, the FIFO is non-empty and the state is SA; otherwise read_i SHALL be ignored.
REQ-022 A simultaneous accepted write and pop SHALL leave the count unchanged.
REQ-023 The state machine SHALL have exactly three states: IDLE, VA and SA.
REQ-024 IDLE: an accepted write with label HEAD or HEADTAIL SHALL latch out_port_i into out_port_o and move the state to VA on the next edge.
REQ-025 In IDLE, a write with label BODY or TAIL SHALL be dropped and SHALL pulse error_o.
REQ-026 VA: vc_request_o SHALL be 1, combinationally from the state; in every other state it SHALL be 0.
REQ-027 In VA, vc_valid_i high SHALL latch vc_new_i into downstream_vc_o and move the state to SA on the next edge.
REQ-028 In VA, a grant may arrive in the first VA cycle, which gives a minimum head-write-to-SA latency of 2 cycles.
REQ-029 SA: a pop of a flit labelled TAIL or HEADTAIL SHALL move the state to IDLE on the next edge.
REQ-030 vc_valid_i SHALL be ignored outside VA.
REQ-031 In VA or SA, a write with label HEAD or HEADTAIL SHALL be dropped and SHALL pulse error_o.
REQ-032 In VA or SA, BODY and TAIL writes SHALL be accepted subject to REQ-020.
REQ-033 A write to a full FIFO without a same-cycle pop SHALL be dropped and SHALL pulse error_o.
REQ-034 error_o SHALL be registered, asserting exactly one cycle after the offending write.
REQ-035 out_port_o and downstream_vc_o SHALL hold their values until the next head flit or grant, including while in IDLE.
REQ-036 In the cycle that leaves SA, a head write in the same cycle as the tail pop SHALL be dropped because the state is still SA; upstream ensures this only follows idle_o.

Reset
REQ-037 While rst is high, the block SHALL immediately set the state to IDLE, both pointers and the count to 0, and out_port_o and downstream_vc_o to 0.
REQ-038 While rst is high, the outputs SHALL be: is_empty_o=1, is_full_o=0, idle_o=1, vc_request_o=0, switch_request_o=0, error_o=0.
REQ-039 A reset asserted mid-packet SHALL discard all stored flits and the packet context; FIFO storage contents need not be cleared.

Verification
REQ-040 Scenario 1: write HEAD(out_port_i=2), BODY, TAIL on consecutive cycles, grant vc_new_i=1 on the first VA cycle, read_i held high -> vc_request_o high for 1 cycle, out_port_o=2, downstream_vc_o=1, 3 pops in order, state back to IDLE, idle_o=1.
REQ-041 Scenario 2: HEADTAIL write, grant withheld for 5 cycles -> vc_request_o high for 6 cycles, switch_request_o=0 until the grant, 1 pop, then idle_o=1.
REQ-042 Scenario 3: BUFFER_SIZE=8, HEAD plus 7 BODY with no reads, then a 9th write -> is_full_o=1, error_o pulses once, count stays 8; a write plus pop in the same full cycle is accepted with no error.
REQ-043 Scenario 4: BODY written in IDLE, and HEAD written during SA -> each dropped with one error_o pulse, and the FIFO count is unchanged.
REQ-044 Scenario 5: more than 8 packets streamed through continuously -> pointers wrap with no loss or reordering, checked against a scoreboard.
REQ-045 Scenario 6: rst asserted in SA with 3 flits stored -> is_empty_o=1, idle_o=1 and downstream_vc_o=0 without waiting for a clock edge.
